// File: rtl/ysyx_23060072_pipe_reg.sv
// ---------------------------------------------------------------------------
// ysyx_23060072_pipe_reg
// Valid/ready pipeline register between two core stages, with controller
// hold (stall) and flush (clean) inputs and a saturating stall counter.
//
//   SKID=1 : two-entry skid buffer (head + skid). in_ready_o comes from a
//            register, so there is no combinational path out_ready_i -> in_ready_o.
//   SKID=0 : single entry, in_ready_o computed combinationally from out_ready_i.
//
// Ports
//   clk, rst                 clock, async active-high reset
//   in_valid_i/in_ready_o    upstream handshake
//   in_ctrl_i/in_data_i      upstream control / data payload
//   hold_i                   freeze everything (no transfers, state kept)
//   flush_i                  drop all held and incoming beats (beats hold_i)
//   out_valid_o/out_ready_i  downstream handshake
//   out_ctrl_o/out_data_o    head payload
//   occupancy_o              beats held (state encoding)
//   stall_cnt_o              cycles with a valid head that could not leave
// ---------------------------------------------------------------------------
module ysyx_23060072_pipe_reg #(
    parameter int                 CTRL_W   = 16,
    parameter int                 DATA_W   = 128,
    parameter logic [CTRL_W-1:0]  CTRL_RST = '0,
    parameter int                 SKID     = 1,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t            st, st_nxt;
    logic [CTRL_W-1:0] head_ctrl, head_ctrl_nxt, skid_ctrl, skid_ctrl_nxt;
    logic [DATA_W-1:0] head_data, head_data_nxt, skid_data, skid_data_nxt;
    logic              rdy_q;
    logic [CNT_W-1:0]  stall_cnt;
    logic              do_in, do_out, out_eff_rdy;

    assign out_valid_o = (st != EMPTY);
    assign out_ctrl_o  = head_ctrl;
    assign out_data_o  = head_data;
    assign occupancy_o = st;
    assign stall_cnt_o = stall_cnt;

    // Downstream ready as seen by the block once hold/flush are applied.
    assign out_eff_rdy = out_ready_i & ~hold_i & ~flush_i;
    assign do_out      = out_valid_o & out_eff_rdy;
    assign do_in       = in_valid_i & in_ready_o;

    generate
        if (SKID != 0) begin : g_skid
            // rdy_q tracks "not full" one cycle late; hold/flush gate it
            // directly so a stall takes effect in the cycle it is raised.
            assign in_ready_o = rdy_q & ~hold_i & ~flush_i;
        end else begin : g_single
            assign in_ready_o = (~out_valid_o | out_ready_i) & ~hold_i & ~flush_i;
        end
    endgenerate

    always_comb begin
        st_nxt        = st;
        head_ctrl_nxt = head_ctrl;
        head_data_nxt = head_data;
        skid_ctrl_nxt = skid_ctrl;
        skid_data_nxt = skid_data;
        if (flush_i) begin
            // out_data keeps its value; only control is forced to the NOP code
            st_nxt        = EMPTY;
            head_ctrl_nxt = CTRL_RST;
        end else begin
            case (st)
                EMPTY: begin
                    if (do_in) begin
                        st_nxt        = ONE;
                        head_ctrl_nxt = in_ctrl_i;
                        head_data_nxt = in_data_i;
                    end
                end
                ONE: begin
                    if (do_in && do_out) begin
                        head_ctrl_nxt = in_ctrl_i;
                        head_data_nxt = in_data_i;
                    end else if (do_in) begin
                        // only reachable with SKID=1
                        st_nxt        = TWO;
                        skid_ctrl_nxt = in_ctrl_i;
                        skid_data_nxt = in_data_i;
                    end else if (do_out) begin
                        st_nxt        = EMPTY;
                        head_ctrl_nxt = CTRL_RST;   // bubble
                    end
                end
                TWO: begin
                    // in_ready is low while full, so only a drain can happen
                    if (do_out) begin
                        st_nxt        = ONE;
                        head_ctrl_nxt = skid_ctrl;
                        head_data_nxt = skid_data;
                    end
                end
                default: st_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st        <= EMPTY;
            head_ctrl <= CTRL_RST;
            head_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            rdy_q     <= 1'b0;
            stall_cnt <= '0;
        end else begin
            st        <= st_nxt;
            head_ctrl <= head_ctrl_nxt;
            head_data <= head_data_nxt;
            skid_ctrl <= skid_ctrl_nxt;
            skid_data <= skid_data_nxt;
            rdy_q     <= (st_nxt != TWO);
            if (out_valid_o && !out_eff_rdy && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_pipe_reg.sv
module tb_ysyx_23060072_pipe_reg;

    logic         clk = 1'b0;
    logic         rst;
    // SKID=1 instance
    logic         in_valid, in_ready, hold, flush, out_valid, out_ready;
    logic [15:0]  in_ctrl, out_ctrl;
    logic [127:0] in_data, out_data;
    logic [1:0]   occ;
    logic [3:0]   cnt;
    // SKID=0 instance
    logic         b_in_valid, b_in_ready, b_hold, b_flush, b_out_valid, b_out_ready;
    logic [7:0]   b_in_ctrl, b_out_ctrl;
    logic [31:0]  b_in_data, b_out_data;
    logic [1:0]   b_occ;
    logic [7:0]   b_cnt;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] NOP = 16'h00AA;

    ysyx_23060072_pipe_reg #(
        .CTRL_W(16), .DATA_W(128), .CTRL_RST(NOP), .SKID(1), .CNT_W(4)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data),
        .hold_i(hold), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_ctrl_o(out_ctrl), .out_data_o(out_data),
        .occupancy_o(occ), .stall_cnt_o(cnt)
    );

    ysyx_23060072_pipe_reg #(
        .CTRL_W(8), .DATA_W(32), .CTRL_RST(8'h00), .SKID(0), .CNT_W(8)
    ) dut0 (
        .clk(clk), .rst(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
        .in_ctrl_i(b_in_ctrl), .in_data_i(b_in_data),
        .hold_i(b_hold), .flush_i(b_flush),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
        .out_ctrl_o(b_out_ctrl), .out_data_o(b_out_data),
        .occupancy_o(b_occ), .stall_cnt_o(b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_ctrl = '0; in_data = '0; hold = 0; flush = 0; out_ready = 0;
        b_in_valid = 0; b_in_ctrl = '0; b_in_data = '0; b_hold = 0; b_flush = 0; b_out_ready = 0;

        // ---- reset state
        #2;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("rst_data", out_data, 128'(0));
        chk("rst_occ", 128'(occ), 128'(0));
        chk("rst_cnt", 128'(cnt), 128'(0));
        chk("rst_inrdy", 128'(in_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rel_inrdy0", 128'(in_ready), 128'(0));
        tick();
        chk("rel_inrdy1", 128'(in_ready), 128'(1));

        // ---- stream 1..8, latency 1
        out_ready = 1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1; in_data = 128'(i); in_ctrl = 16'(16'h100 + i);
            tick();
            chk("stream_data", out_data, 128'(i));
            chk("stream_ctrl", 128'(out_ctrl), 128'(16'h100 + i));
            chk("stream_occ", 128'(occ), 128'(1));
        end
        in_valid = 0;
        tick();
        chk("stream_cnt", 128'(cnt), 128'(0));
        chk("bubble_valid", 128'(out_valid), 128'(0));
        chk("bubble_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("bubble_occ", 128'(occ), 128'(0));

        // ---- backpressure A,B,C
        out_ready = 0;
        in_valid = 1; in_data = 128'hA; in_ctrl = 16'h0A;
        tick();
        chk("bp_A", out_data, 128'hA);
        in_data = 128'hB; in_ctrl = 16'h0B;
        tick();
        chk("bp_occ2", 128'(occ), 128'(2));
        in_data = 128'hC; in_ctrl = 16'h0C;
        #1 chk("bp_inrdy0", 128'(in_ready), 128'(0));
        tick();
        tick();
        chk("bp_cnt3", 128'(cnt), 128'(3));
        chk("bp_headA", out_data, 128'hA);
        out_ready = 1;
        #1 chk("bp_noreadypath", 128'(in_ready), 128'(0));
        tick();
        chk("bp_B", out_data, 128'hB);
        chk("bp_inrdy1", 128'(in_ready), 128'(1));
        tick();
        chk("bp_C", out_data, 128'hC);
        in_valid = 0;
        tick();
        chk("bp_empty", 128'(out_valid), 128'(0));
        chk("bp_cnt_keep", 128'(cnt), 128'(3));

        // ---- flush at occupancy 2
        out_ready = 0;
        in_valid = 1; in_data = 128'hD; in_ctrl = 16'h0D;
        tick();
        in_data = 128'hE; in_ctrl = 16'h0E;
        tick();
        chk("fl_occ2", 128'(occ), 128'(2));
        flush = 1; in_data = 128'hF; in_ctrl = 16'h0F;
        #1 chk("fl_inrdy", 128'(in_ready), 128'(0));
        tick();
        chk("fl_valid", 128'(out_valid), 128'(0));
        chk("fl_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("fl_occ", 128'(occ), 128'(0));
        chk("fl_data_kept", out_data, 128'hD);
        chk("fl_cnt", 128'(cnt), 128'(5));
        flush = 0; in_valid = 0;
        #1 chk("fl_inrdy_back", 128'(in_ready), 128'(1));
        tick();
        chk("fl_lost", 128'(out_valid), 128'(0));

        // ---- hold for 4 cycles, then hold+flush
        out_ready = 1;
        in_valid = 1; in_data = 128'h16; in_ctrl = 16'h16;
        tick();
        in_data = 128'h17; in_ctrl = 16'h17; hold = 1;
        #1 chk("hold_inrdy", 128'(in_ready), 128'(0));
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("hold_data", out_data, 128'h16);
            chk("hold_occ", 128'(occ), 128'(1));
            chk("hold_cnt", 128'(cnt), 128'(6 + k));
        end
        flush = 1;
        tick();
        chk("hf_valid", 128'(out_valid), 128'(0));
        chk("hf_ctrl", 128'(out_ctrl), 128'(NOP));
        chk("hf_occ", 128'(occ), 128'(0));
        hold = 0; flush = 0;

        // ---- stall counter saturation
        out_ready = 0;
        in_data = 128'h20; in_ctrl = 16'h20;
        tick();
        in_valid = 0;
        repeat (20) tick();
        chk("sat_cnt", 128'(cnt), 128'(15));
        chk("sat_occ", 128'(occ), 128'(1));

        // ---- async reset between edges at occupancy 2
        in_valid = 1; in_data = 128'h21; in_ctrl = 16'h21;
        tick();
        in_valid = 0;
        chk("ar_occ2", 128'(occ), 128'(2));
        #2 rst = 1;
        #1;
        chk("ar_valid", 128'(out_valid), 128'(0));
        chk("ar_occ", 128'(occ), 128'(0));
        chk("ar_cnt", 128'(cnt), 128'(0));
        chk("ar_data", out_data, 128'(0));
        rst = 0;
        tick();
        tick();
        chk("ar_no_beat", 128'(out_valid), 128'(0));

        // ---- SKID=0: combinational ready, replace on in+out
        b_in_valid = 1; b_in_data = 32'h11; b_in_ctrl = 8'h11;
        #1 chk("s0_rdy_empty", 128'(b_in_ready), 128'(1));
        tick();
        chk("s0_data11", 128'(b_out_data), 128'(32'h11));
        chk("s0_occ1", 128'(b_occ), 128'(1));
        chk("s0_rdy_full", 128'(b_in_ready), 128'(0));
        b_out_ready = 1;
        #1 chk("s0_rdy_comb", 128'(b_in_ready), 128'(1));
        b_in_data = 32'h22; b_in_ctrl = 8'h22;
        tick();
        chk("s0_data22", 128'(b_out_data), 128'(32'h22));
        chk("s0_occ_keep", 128'(b_occ), 128'(1));
        b_in_valid = 0;
        tick();
        chk("s0_empty", 128'(b_out_valid), 128'(0));
        chk("s0_ctrl_nop", 128'(b_out_ctrl), 128'(0));
        chk("s0_cnt", 128'(b_cnt), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060072_pipe_reg.md
YSYX_23060072_PIPE_REG -- requirements
Module: ysyx_23060072_pipe_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 16: width of control payload (valid-qualified fields: wb_flag, load/store, alu_op, etc.).
REQ-002 SHALL have parameter DATA_W, default 128: width of data payload (pc, operands, imm, addresses).
REQ-003 SHALL have parameter CTRL_RST, default all-zero CTRL_W bits: control value on reset/flush (ALU_NOP encoding).
REQ-004 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered ready; 0 = single entry with combinational ready.
REQ-005 SHALL have parameter CNT_W, default 16: width of stall counter.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-high.
REQ-008 in_valid_i  input  1  upstream beat valid.
REQ-009 in_ready_o  output  1  block accepts beat this cycle.
REQ-010 in_ctrl_i  input  CTRL_W  upstream control payload.
REQ-011 in_data_i  input  DATA_W  upstream data payload.
REQ-012 hold_i  input  1  controller stall; freezes block.
REQ-013 flush_i  input  1  controller clean; discards all held and incoming beats.
REQ-014 out_valid_o  output  1  downstream beat valid.
REQ-015 out_ready_i  input  1  downstream accepts beat.
REQ-016 out_ctrl_o  output  CTRL_W  head control payload.
REQ-017 out_data_o  output  DATA_W  head data payload.
REQ-018 occupancy_o  output  2  beats held, 0..2 (0..1 when SKID=0).
REQ-019 stall_cnt_o  output  CNT_W  cycles with out_valid_o=1 and effective out_ready=0.

Function
REQ-020 Input transfer SHALL occur iff in_valid_i & in_ready_o; output transfer iff out_valid_o & out_ready_i & !hold_i & !flush_i.
REQ-021 hold_i=1 SHALL force in_ready_o=0, block output transfer, and keep all payload, valid and occupancy unchanged.
REQ-022 flush_i=1 SHALL force in_ready_o=0; next cycle occupancy 0, out_valid_o=0, out_ctrl_o=CTRL_RST; out_data_o keeps prior value; flush has priority over hold_i and all transfers.
REQ-023 Beats SHALL exit in arrival order; no beat dropped or duplicated except by flush.
REQ-024 SKID=1: states EMPTY(0), ONE(1), TWO(2); head register drives outputs, skid register holds second beat.
REQ-025 SKID=1: in_ready_o SHALL be a registered signal equal to (state!=TWO) & !hold_i & !flush_i, no combinational path from out_ready_i.
REQ-026 SKID=1 transitions: EMPTY+in -> ONE; ONE+in+out -> ONE (head loads new beat); ONE+in only -> TWO (beat into skid); ONE+out only -> EMPTY; TWO+out -> ONE (skid moves to head); else stay.
REQ-027 SKID=1: accepted beat SHALL appear on out_*_o the cycle after acceptance (latency 1) when head free or being drained.
REQ-028 SKID=0: in_ready_o = (!out_valid_o | out_ready_i) & !hold_i & !flush_i, combinational; states EMPTY/ONE only; simultaneous in+out replaces head.
REQ-029 out_ctrl_o SHALL equal CTRL_RST whenever out_valid_o=0 following an output transfer with no replacement (bubble insertion); out_data_o need not change.
REQ-030 stall_cnt_o SHALL increment by 1 per qualifying cycle, saturate at all-ones, clear only on rst.
REQ-031 occupancy_o SHALL equal the state encoding, registered.

Reset
REQ-032 On rst=1, asynchronously: out_valid_o=0, out_ctrl_o=CTRL_RST, out_data_o=0, skid entry empty/zero, occupancy_o=0, stall_cnt_o=0, in_ready_o=0.
REQ-033 First rising edge after rst deassert SHALL set in_ready_o=1 (SKID=1) if hold_i=0 and flush_i=0.
REQ-034 rst asserted mid-transfer SHALL discard all beats; no partial beat emerges after release.

Verification
REQ-035 Stream: SKID=1, in_valid=1 with data 1..8 on consecutive cycles, out_ready=1 -> out_data 1..8 one cycle later each, occupancy stays 1, stall_cnt 0.
REQ-036 Backpressure: out_ready=0 three cycles while feeding A,B,C -> A,B accepted, in_ready=0 after B, occupancy=2, stall_cnt=3; release -> A,B,C in order.
REQ-037 Flush: occupancy=2, flush_i=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=CTRL_RST, occupancy=0, incoming beat lost.
REQ-038 Hold: hold_i=1 for 4 cycles with out_ready=1 -> outputs, occupancy unchanged, in_ready=0; hold+flush together -> flush wins.
REQ-039 Saturation: CNT_W=4, out_ready=0 for 20 cycles with out_valid=1 -> stall_cnt_o stays 15.
REQ-040 Async reset: assert rst between edges at occupancy=2 -> out_valid=0, occupancy=0 immediately, before next clk edge.
